// File: rtl/dft_seq_pkg.sv
// Shared types for the dft kernel run sequencer: FSM states and error codes.
package dft_seq_pkg;

    localparam int ERR_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ERROR
    } seq_state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_code_e;

endpackage

// File: rtl/dft_seq_watchdog.sv
// Stall watchdog: counts enabled cycles since the last clear and flags expiry
// on the cycle the count sits at TIMEOUT-1; the count then holds until cleared.
module dft_seq_watchdog #(
    parameter int TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT) + 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt;
    logic         at_last;

    assign at_last = (cnt == LAST);
    assign expire  = en && !clr && at_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !at_last) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dft_run_sequencer.sv
// Runs a batch of frames through the dft kernel's ap_start/ap_ready/ap_done/ap_continue
// handshake with at most MAX_OUT frames in flight, plus batch cycle meter and stall watchdog.
module dft_run_sequencer
    import dft_seq_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int MAX_OUT = 2,
    parameter int TIMEOUT = 4096,
    parameter int CYC_W   = 32
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_frames,
    input  logic             err_clear,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             batch_done,
    output logic             err,
    output logic [ERR_W-1:0] err_code,
    output logic [CNT_W-1:0] frames_done,
    output logic [CYC_W-1:0] batch_cycles
);

    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

    seq_state_e       state;
    err_code_e        err_q;
    logic [CNT_W-1:0] frames;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] completed;
    logic [CNT_W-1:0] outstanding;
    logic             metering;

    logic             accept;
    logic             active;
    logic             issue;
    logic             spurious;
    logic             complete;
    logic             wd_expire;
    logic [CNT_W-1:0] issued_nxt;
    logic [CNT_W-1:0] completed_nxt;

    assign active        = (state == RUN) || (state == DRAIN);
    assign cmd_ready     = (state == IDLE) && !ap_rst;
    assign accept        = cmd_valid && cmd_ready;
    assign ap_start      = (state == RUN) && (issued < frames) && (outstanding < MAX_OUT_C);
    assign issue         = ap_start && ap_ready;
    // A done with nothing in flight is only legal when the matching start lands the same cycle.
    assign spurious      = active && ap_done && (outstanding == '0) && !issue;
    assign complete      = active && ap_done && !spurious;
    assign issued_nxt    = issued + CNT_W'(issue);
    assign completed_nxt = completed + CNT_W'(complete);

    assign busy          = active;
    assign err           = (state == ERROR);
    assign ap_continue   = (state != ERROR);
    assign err_code      = err_q;
    assign frames_done   = completed;

    dft_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (ap_clk),
        .rst    (ap_rst),
        .clr    (accept || issue || complete),
        .en     (active),
        .expire (wd_expire)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state        <= IDLE;
            err_q        <= ERR_NONE;
            frames       <= '0;
            issued       <= '0;
            completed    <= '0;
            outstanding  <= '0;
            metering     <= 1'b0;
            batch_cycles <= '0;
            batch_done   <= 1'b0;
        end else begin
            batch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        frames       <= cmd_frames;
                        issued       <= '0;
                        completed    <= '0;
                        outstanding  <= '0;
                        metering     <= 1'b0;
                        batch_cycles <= '0;
                        if (cmd_frames == '0) begin
                            state      <= DONE;
                            batch_done <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN, DRAIN: begin
                    // The cycle that trips an error is still a working cycle for the meter.
                    if (ap_start || metering) begin
                        metering <= 1'b1;
                        if (batch_cycles != '1) begin
                            batch_cycles <= batch_cycles + 1'b1;
                        end
                    end
                    if (spurious || wd_expire) begin
                        state <= ERROR;
                        if (err_q == ERR_NONE) begin
                            err_q <= spurious ? ERR_SPURIOUS : ERR_TIMEOUT;
                        end
                    end else begin
                        issued    <= issued_nxt;
                        completed <= completed_nxt;
                        case ({issue, complete})
                            2'b10:   outstanding <= outstanding + 1'b1;
                            2'b01:   outstanding <= outstanding - 1'b1;
                            default: outstanding <= outstanding;
                        endcase
                        if (state == RUN) begin
                            if (issued_nxt == frames) begin
                                state <= DRAIN;
                            end
                        end else if (completed_nxt == frames) begin
                            state      <= DONE;
                            batch_done <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERROR: begin
                    if (err_clear) begin
                        state <= IDLE;
                        err_q <= ERR_NONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dft_run_sequencer.sv
// Directed bench for dft_run_sequencer: batch flow, in-flight cap, same-cycle events,
// empty batch, watchdog and spurious-done errors, and asynchronous reset mid-batch.
module tb_dft_run_sequencer;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_frames;
    logic        err_clear;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_continue;
    logic        busy;
    logic        batch_done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] frames_done;
    logic [31:0] batch_cycles;

    int n_cmp = 0;
    int n_bad = 0;

    dft_run_sequencer #(
        .CNT_W   (16),
        .MAX_OUT (2),
        .TIMEOUT (64),
        .CYC_W   (32)
    ) dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_frames   (cmd_frames),
        .err_clear    (err_clear),
        .ap_start     (ap_start),
        .ap_ready     (ap_ready),
        .ap_done      (ap_done),
        .ap_continue  (ap_continue),
        .busy         (busy),
        .batch_done   (batch_done),
        .err          (err),
        .err_code     (err_code),
        .frames_done  (frames_done),
        .batch_cycles (batch_cycles)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] n);
        cmd_frames = n;
        cmd_valid  = 1'b1;
        tick();
        cmd_valid  = 1'b0;
    endtask

    initial begin
        int age;
        int issues;
        int pulses;
        int pulse_cyc;
        int done_q[$];

        ap_rst     = 1'b1;
        cmd_valid  = 1'b0;
        cmd_frames = '0;
        err_clear  = 1'b0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;

        // Reset values
        #12;
        chk("rst_ap_start", 32'(ap_start), 0);
        chk("rst_ap_continue", 32'(ap_continue), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_batch_done", 32'(batch_done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_frames_done", 32'(frames_done), 0);
        chk("rst_batch_cycles", batch_cycles, 0);
        ap_rst = 1'b0;
        tick();
        chk("rst_cmd_ready", 32'(cmd_ready), 1);

        // 1: three frames, ready one cycle after start, done 34 cycles after ready
        age = 0; issues = 0; pulses = 0; pulse_cyc = -1;
        accept(16'd3);
        for (int c = 0; c < 100; c++) begin
            if (batch_done) begin
                pulses++;
                pulse_cyc = c;
            end
            if (c == 20) chk("t1_start_capped", 32'(ap_start), 0);
            ap_ready = 1'b0;
            ap_done  = 1'b0;
            if (ap_start) begin
                if (age == 1) begin
                    ap_ready = 1'b1;
                    age      = 0;
                    issues++;
                    done_q.push_back(c + 34);
                end else begin
                    age = 1;
                end
            end
            if (done_q.size() > 0 && done_q[0] == c) begin
                ap_done = 1'b1;
                void'(done_q.pop_front());
            end
            tick();
        end
        ap_ready = 1'b0;
        ap_done  = 1'b0;
        chk("t1_issues", 32'(issues), 3);
        chk("t1_frames_done", 32'(frames_done), 3);
        chk("t1_pulses", 32'(pulses), 1);
        chk("t1_pulse_cycle", 32'(pulse_cyc), 72);
        chk("t1_batch_cycles", batch_cycles, 72);
        chk("t1_busy_after", 32'(busy), 0);
        chk("t1_cmd_ready", 32'(cmd_ready), 1);

        // 2: four frames, ready tied high, done withheld -> capped at two in flight
        accept(16'd4);
        ap_ready = 1'b1;
        tick();
        tick();
        chk("t2_cap_c2", 32'(ap_start), 0);
        repeat (7) tick();
        chk("t2_cap_c9", 32'(ap_start), 0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("t2_resume", 32'(ap_start), 1);
        tick();
        chk("t2_recap", 32'(ap_start), 0);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        tick();
        chk("t2_drain_busy", 32'(busy), 1);
        chk("t2_drain_start", 32'(ap_start), 0);
        ap_done = 1'b1;
        tick();
        tick();
        ap_done  = 1'b0;
        ap_ready = 1'b0;
        chk("t2_batch_done", 32'(batch_done), 1);
        chk("t2_frames_done", 32'(frames_done), 4);
        chk("t2_batch_cycles", batch_cycles, 15);
        tick();

        // 3: ready and done in the same cycle with one frame in flight
        accept(16'd2);
        ap_ready = 1'b1;
        tick();
        ap_ready = 1'b0;
        tick();
        ap_ready = 1'b1;
        ap_done  = 1'b1;
        tick();
        ap_ready = 1'b0;
        chk("t3_no_err", 32'(err), 0);
        chk("t3_busy", 32'(busy), 1);
        chk("t3_frames_mid", 32'(frames_done), 1);
        chk("t3_start_low", 32'(ap_start), 0);
        tick();
        ap_done = 1'b0;
        chk("t3_batch_done", 32'(batch_done), 1);
        chk("t3_frames_done", 32'(frames_done), 2);
        chk("t3_no_err_end", 32'(err), 0);
        tick();

        // 4: empty batch
        chk("t4_cmd_ready", 32'(cmd_ready), 1);
        accept(16'd0);
        chk("t4_batch_done", 32'(batch_done), 1);
        chk("t4_no_start", 32'(ap_start), 0);
        chk("t4_batch_cycles", batch_cycles, 0);
        chk("t4_frames_done", 32'(frames_done), 0);
        chk("t4_busy", 32'(busy), 0);
        tick();
        chk("t4_pulse_gone", 32'(batch_done), 0);
        chk("t4_idle", 32'(cmd_ready), 1);

        // 5: kernel never accepts -> watchdog after 64 cycles
        accept(16'd1);
        repeat (63) tick();
        chk("t5_not_yet", 32'(err), 0);
        chk("t5_start_held", 32'(ap_start), 1);
        tick();
        chk("t5_err", 32'(err), 1);
        chk("t5_code", 32'(err_code), 1);
        chk("t5_start_low", 32'(ap_start), 0);
        chk("t5_continue_low", 32'(ap_continue), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_cycles", batch_cycles, 64);
        chk("t5_no_cmd", 32'(cmd_ready), 0);
        repeat (2) tick();
        chk("t5_cycles_frozen", batch_cycles, 64);
        chk("t5_code_sticky", 32'(err_code), 1);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("t5_cleared", 32'(err), 0);
        chk("t5_code_clear", 32'(err_code), 0);
        chk("t5_cmd_ready", 32'(cmd_ready), 1);
        chk("t5_continue", 32'(ap_continue), 1);

        // 6: done with nothing in flight -> spurious error
        accept(16'd2);
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("t6_err", 32'(err), 1);
        chk("t6_code", 32'(err_code), 2);
        chk("t6_frames", 32'(frames_done), 0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Asynchronous reset in the middle of a batch
        accept(16'd5);
        ap_ready = 1'b1;
        tick();
        tick();
        ap_done = 1'b1;
        tick();
        ap_done = 1'b0;
        chk("t6_pre_busy", 32'(busy), 1);
        chk("t6_pre_frames", 32'(frames_done), 1);
        #2;
        ap_rst = 1'b1;
        #1;
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_start", 32'(ap_start), 0);
        chk("t6_rst_frames", 32'(frames_done), 0);
        chk("t6_rst_cycles", batch_cycles, 0);
        chk("t6_rst_err_code", 32'(err_code), 0);
        chk("t6_rst_continue", 32'(ap_continue), 1);
        ap_ready = 1'b0;
        #2;
        ap_rst = 1'b0;
        tick();
        chk("t6_post_cmd_ready", 32'(cmd_ready), 1);
        chk("t6_post_busy", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
